// File: rtl/dmem_bus_bridge_pkg.sv
// Shared load/store constants, bridge FSM states and byte-lane helpers
// for the M-stage data bus bridge.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } dmem_state_t;

  function automatic logic [3:0] be_for(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    unique case (f3[1:0])
      2'b00:   be_for = 4'b0001 << off;
      2'b01:   be_for = off[1] ? 4'b1100 : 4'b0011;
      default: be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    unique case (f3[1:0])
      2'b10:   is_aligned = (off == 2'b00);
      2'b01:   is_aligned = ~off[0];
      default: is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    unique case (f3[1:0])
      2'b00:   wdata_for = {4{wd[7:0]}};
      2'b01:   wdata_for = {2{wd[15:0]}};
      default: wdata_for = wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Valid/ready data bus between the M-stage bridge (master)
// and the external memory system (slave).
interface dmem_bus_if #(
  parameter int ADDR_W = 32
) ();

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr,
    output bus_wdata, bus_be,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr,
    input  bus_wdata, bus_be,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/dmem_bus_bridge_load_extend.sv
// Load lane select plus sign/zero extension of a full bus word.
// Purely combinational.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    unique case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// M-stage bridge from the pipeline memory request to a valid/ready bus.
// Optional bus timeout: define DMEM_TIMEOUT_EN.
module dmem_bus_bridge
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  dmem_bus_if.master  bus
);

  dmem_state_t       r_state;
  dmem_state_t       w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [31:0]       r_rdata;
  logic [31:0]       w_ext;
  logic              w_req;
  logic              w_aligned;
  logic              w_go;
  logic              w_timeout;
  logic              w_store;

  assign w_req     = MemReadM | MemWriteM;
  assign w_store   = MemWriteM & ~MemReadM;
  assign w_aligned = is_aligned(Funct3M, ALUResultM[1:0]);
  assign w_go      = w_req & w_aligned;

  load_extend u_ext (
    .i_funct3 (r_f3),
    .i_off    (r_off),
    .i_rdata  (bus.bus_rdata),
    .o_data   (w_ext)
  );

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       w_wait;

  assign w_wait    = (r_state == REQ) | (r_state == RESP);
  assign w_timeout = w_wait & (r_cnt == 8'(TIMEOUT_CYC));

  // restarts on every state entry so REQ and RESP each get a full budget
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= 8'd0;
    else if (!w_wait || w_next != r_state)
      r_cnt <= 8'd0;
    else
      r_cnt <= r_cnt + 8'd1;
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC == 0);
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_go) w_next = REQ;
      REQ: begin
        if (w_timeout)
          w_next = DONE;
        else if (bus.bus_ready)
          w_next = r_we ? DONE : RESP;
      end
      RESP: begin
        if (w_timeout || bus.bus_rvalid)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_we    <= w_store;
        r_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
        r_wdata <= w_store ? wdata_for(Funct3M, WriteDataM)
                           : 32'd0;
        r_be    <= be_for(Funct3M, ALUResultM[1:0]);
        r_f3    <= Funct3M;
        r_off   <= ALUResultM[1:0];
        r_rdata <= 32'd0;
      end else if (w_timeout) begin
        r_rdata <= 32'd0;
      end else if (r_state == RESP && bus.bus_rvalid) begin
        r_rdata <= w_ext;
      end
    end
  end

  // pipeline-facing outputs are forced low while reset is held
  always_comb begin
    StallM    = 1'b0;
    MisalignM = 1'b0;
    ReadDataM = 32'd0;
    unique case (1'b1)
      (r_state == IDLE): begin
        StallM    = rst & w_go;
        MisalignM = rst & w_req & ~w_aligned;
      end
      (r_state == REQ):  StallM = rst;
      (r_state == RESP): StallM = rst;
      (r_state == DONE): ReadDataM = r_we ? 32'd0 : r_rdata;
      default: ;
    endcase
  end

  assign BusErrM       = w_timeout;
  assign bus.bus_valid = (r_state == REQ) & ~w_timeout;
  assign bus.bus_we    = (r_state == REQ) & r_we;
  assign bus.bus_addr  = (r_state == REQ) ? r_addr : '0;
  assign bus.bus_wdata = (r_state == REQ) ? r_wdata : 32'd0;
  assign bus.bus_be    = (r_state == REQ) ? r_be : 4'd0;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: loads, stores, strobes,
// extension, misalignment, bus stalls and asynchronous reset.
module tb_dmem_bus_bridge;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_bus_if #(.ADDR_W(32)) bus ();

  dmem_bus_bridge #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done;
    int          stalls;
    int          vcyc;
    bit          unstable;
    bit          misal;
    bit          buserr;
    logic [31:0] rdout;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } res_t;

  // Drives one access and plays the bus slave; called at posedge+1.
  task automatic run_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  int          rdy_wait,
    input  logic [31:0] rdata,
    input  bit          no_rsp,
    output res_t        r
  );
    int waited  = 0;
    bit pending = 0;
    r.done = 0; r.stalls = 0; r.vcyc = 0;
    r.unstable = 0; r.misal = 0; r.buserr = 0;
    r.rdout = 0; r.addr = 0; r.wdata = 0;
    r.be = 0; r.we = 0;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      bus.bus_ready  = bus.bus_valid && (waited >= rdy_wait);
      bus.bus_rvalid = pending && !no_rsp;
      bus.bus_rdata  = bus.bus_rvalid ? rdata : 32'h0;
      #1;
      if (MisalignM) r.misal = 1;
      if (BusErrM) r.buserr = 1;
      if (bus.bus_valid) begin
        if (r.vcyc == 0) begin
          r.addr = bus.bus_addr; r.wdata = bus.bus_wdata;
          r.be = bus.bus_be; r.we = bus.bus_we;
        end else if (bus.bus_addr !== r.addr ||
                     bus.bus_be !== r.be ||
                     bus.bus_wdata !== r.wdata ||
                     bus.bus_we !== r.we) begin
          r.unstable = 1;
        end
        r.vcyc++;
      end
      if (bus.bus_rvalid) pending = 0;
      if (bus.bus_valid && bus.bus_ready) begin
        if (!bus.bus_we) pending = 1;
      end else if (bus.bus_valid) begin
        waited++;
      end
      if (StallM) r.stalls++;
      else begin
        r.done = 1;
        r.rdout = ReadDataM;
      end
      @(posedge clk);
      #1;
      if (r.done) break;
    end
    MemReadM = 0; MemWriteM = 0; Funct3M = 0;
    ALUResultM = 0; WriteDataM = 0;
    bus.bus_ready = 0; bus.bus_rvalid = 0; bus.bus_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    MemReadM = 1; MemWriteM = 0; Funct3M = F3_LW;
    ALUResultM = 32'h100; WriteDataM = 0;
    bus.bus_ready = 0; bus.bus_rvalid = 0; bus.bus_rdata = 0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (StallM !== 1'b0 || bus.bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: stall=%b valid=%b want 0 0",
               StallM, bus.bus_valid);
    end
    MemReadM = 0; Funct3M = 0; ALUResultM = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #2;
    n_tests++;
    if ({StallM, MisalignM, BusErrM, bus.bus_valid,
         bus.bus_we, bus.bus_be, ReadDataM, bus.bus_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_out: rd=%h be=%b stall=%b want all 0",
               ReadDataM, bus.bus_be, StallM);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_word();
    res_t r;
    run_access(1, 0, F3_LW, 32'h100, 0, 0, 32'hDEADBEEF, 0, r);
    n_tests++;
    if (r.done !== 1 || r.stalls != 3) begin
      n_fail++;
      $display("FAIL lw_stall: done=%0d stalls=%0d want 1 3",
               r.done, r.stalls);
    end
    n_tests++;
    if (r.rdout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_data: got %h want deadbeef", r.rdout);
    end
    n_tests++;
    if (r.addr !== 32'h100 || r.be !== 4'hF || r.we !== 0) begin
      n_fail++;
      $display("FAIL lw_bus: addr=%h be=%b we=%b want 100 1111 0",
               r.addr, r.be, r.we);
    end
    n_tests++;
    if (r.buserr !== 0 || r.misal !== 0) begin
      n_fail++;
      $display("FAIL lw_flags: buserr=%b misal=%b want 0 0",
               r.buserr, r.misal);
    end
    #1;
    n_tests++;
    if (ReadDataM !== 32'h0) begin
      n_fail++;
      $display("FAIL lw_after: got %h want 0", ReadDataM);
    end
  endtask

  task automatic test_stores();
    res_t r;
    run_access(0, 1, F3_LB, 32'h103, 32'hA5, 0, 32'h0, 0, r);
    n_tests++;
    if (r.done !== 1 || r.stalls != 2) begin
      n_fail++;
      $display("FAIL sb_stall: done=%0d stalls=%0d want 1 2",
               r.done, r.stalls);
    end
    n_tests++;
    if (r.be !== 4'b1000 || r.wdata !== 32'hA5A5A5A5 ||
        r.we !== 1 || r.addr !== 32'h100) begin
      n_fail++;
      $display("FAIL sb_bus: be=%b wd=%h we=%b addr=%h want 1000 a5a5a5a5 1 100",
               r.be, r.wdata, r.we, r.addr);
    end
    n_tests++;
    if (r.rdout !== 32'h0) begin
      n_fail++;
      $display("FAIL sb_rdata: got %h want 0", r.rdout);
    end
    run_access(0, 1, F3_LH, 32'h102, 32'h1234, 0, 32'h0, 0, r);
    n_tests++;
    if (r.be !== 4'b1100 || r.wdata !== 32'h12341234 ||
        r.addr !== 32'h100) begin
      n_fail++;
      $display("FAIL sh_bus: be=%b wd=%h addr=%h want 1100 12341234 100",
               r.be, r.wdata, r.addr);
    end
    run_access(0, 1, F3_LW, 32'h104, 32'hCAFEF00D, 0, 32'h0, 0, r);
    n_tests++;
    if (r.be !== 4'b1111 || r.wdata !== 32'hCAFEF00D ||
        r.addr !== 32'h104 || r.stalls != 2) begin
      n_fail++;
      $display("FAIL sw_bus: be=%b wd=%h addr=%h st=%0d want 1111 cafef00d 104 2",
               r.be, r.wdata, r.addr, r.stalls);
    end
  endtask

  task automatic test_extend();
    res_t r;
    run_access(1, 0, F3_LB, 32'h102, 0, 0, 32'h00800000, 0, r);
    n_tests++;
    if (r.rdout !== 32'hFFFFFF80 || r.be !== 4'b0100) begin
      n_fail++;
      $display("FAIL lb: got %h be=%b want ffffff80 0100",
               r.rdout, r.be);
    end
    run_access(1, 0, F3_LBU, 32'h102, 0, 0, 32'h00800000, 0, r);
    n_tests++;
    if (r.rdout !== 32'h00000080) begin
      n_fail++;
      $display("FAIL lbu: got %h want 00000080", r.rdout);
    end
    run_access(1, 0, F3_LH, 32'h102, 0, 0, 32'h80010000, 0, r);
    n_tests++;
    if (r.rdout !== 32'hFFFF8001 || r.be !== 4'b1100) begin
      n_fail++;
      $display("FAIL lh: got %h be=%b want ffff8001 1100",
               r.rdout, r.be);
    end
    run_access(1, 0, F3_LHU, 32'h100, 0, 0, 32'h12348001, 0, r);
    n_tests++;
    if (r.rdout !== 32'h00008001 || r.be !== 4'b0011) begin
      n_fail++;
      $display("FAIL lhu: got %h be=%b want 00008001 0011",
               r.rdout, r.be);
    end
  endtask

  task automatic test_misalign();
    res_t r;
    run_access(1, 0, F3_LW, 32'h102, 0, 0, 32'h0, 0, r);
    n_tests++;
    if (r.misal !== 1 || r.stalls != 0 || r.vcyc != 0 ||
        r.rdout !== 32'h0) begin
      n_fail++;
      $display("FAIL lw_misal: mis=%b st=%0d vc=%0d rd=%h want 1 0 0 0",
               r.misal, r.stalls, r.vcyc, r.rdout);
    end
    run_access(0, 1, F3_LH, 32'h101, 32'h5555, 0, 32'h0, 0, r);
    n_tests++;
    if (r.misal !== 1 || r.stalls != 0 || r.vcyc != 0) begin
      n_fail++;
      $display("FAIL sh_misal: mis=%b st=%0d vc=%0d want 1 0 0",
               r.misal, r.stalls, r.vcyc);
    end
    #1;
    n_tests++;
    if (MisalignM !== 1'b0) begin
      n_fail++;
      $display("FAIL misal_pulse: got %b want 0", MisalignM);
    end
  endtask

  task automatic test_ready_wait();
    res_t r;
    run_access(1, 0, F3_LW, 32'h200, 0, 5, 32'h01020304, 0, r);
    n_tests++;
    if (r.vcyc != 6 || r.unstable !== 0) begin
      n_fail++;
      $display("FAIL rdy_wait: vcyc=%0d unstable=%b want 6 0",
               r.vcyc, r.unstable);
    end
    n_tests++;
    if (r.stalls != 8 || r.rdout !== 32'h01020304) begin
      n_fail++;
      $display("FAIL rdy_data: st=%0d rd=%h want 8 01020304",
               r.stalls, r.rdout);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    run_access(1, 1, F3_LW, 32'h108, 32'h99, 0, 32'h55AA55AA, 0, r);
    n_tests++;
    if (r.we !== 0 || r.rdout !== 32'h55AA55AA) begin
      n_fail++;
      $display("FAIL both_rw: we=%b rd=%h want 0 55aa55aa",
               r.we, r.rdout);
    end
    run_access(1, 0, F3_LBU, 32'h10B, 0, 0, 32'hC3000000, 0, r);
    n_tests++;
    if (r.rdout !== 32'h000000C3 || r.stalls != 3) begin
      n_fail++;
      $display("FAIL b2b_load: rd=%h st=%0d want 000000c3 3",
               r.rdout, r.stalls);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    MemReadM = 1; Funct3M = F3_LW; ALUResultM = 32'h300;
    bus.bus_ready = 0;
    @(posedge clk);
    #2;
    n_tests++;
    if (bus.bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL req_valid: got %b want 1", bus.bus_valid);
    end
    rst = 0;
    #1;
    n_tests++;
    if (bus.bus_valid !== 1'b0 || StallM !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req: valid=%b stall=%b want 0 0",
               bus.bus_valid, StallM);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    bus.bus_ready = 1;
    @(posedge clk);
    #1;
    bus.bus_ready = 0;
    @(posedge clk);
    #1;
    n_tests++;
    if (StallM !== 1'b1 || bus.bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL in_resp: stall=%b valid=%b want 1 0",
               StallM, bus.bus_valid);
    end
    rst = 0;
    #1;
    n_tests++;
    if (StallM !== 1'b0 || bus.bus_valid !== 1'b0 ||
        ReadDataM !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_resp: stall=%b valid=%b rd=%h want 0 0 0",
               StallM, bus.bus_valid, ReadDataM);
    end
    MemReadM = 0; Funct3M = 0; ALUResultM = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    bus.bus_rvalid = 1; bus.bus_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    n_tests++;
    if (ReadDataM !== 32'h0 || StallM !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_rvalid: rd=%h stall=%b want 0 0",
               ReadDataM, StallM);
    end
    bus.bus_rvalid = 0; bus.bus_rdata = 0;
    run_access(1, 0, F3_LW, 32'h300, 0, 0, 32'h11223344, 0, r);
    n_tests++;
    if (r.rdout !== 32'h11223344 || r.stalls != 3) begin
      n_fail++;
      $display("FAIL post_rst: rd=%h st=%0d want 11223344 3",
               r.rdout, r.stalls);
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    res_t r;
    run_access(1, 0, F3_LW, 32'h400, 0, 0, 32'h77777777, 1, r);
    n_tests++;
    if (r.done !== 1 || r.buserr !== 1 || r.rdout !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout: done=%0d err=%b rd=%h want 1 1 0",
               r.done, r.buserr, r.rdout);
    end
    n_tests++;
    if (r.stalls != 7) begin
      n_fail++;
      $display("FAIL to_stall: got %0d want 7", r.stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_stores();
    test_extend();
    test_misalign();
    test_ready_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
